// File: rtl/mm2s_stream_checker.sv
`timescale 1ns/1ps
// mm2s_stream_checker: checks MM2S read-back beats against the soak pattern.
// Optional build macro: MM2S_CHECKER_THROTTLE_EN (LFSR tready throttling).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               arm checker and clear counters (IDLE only)
//   s_axis_t*           AXI4-Stream sink from the DataMover MM2S channel
//   busy/done/pass      pass status (done is a 1-cycle pulse, pass a level)
//   word_count          beats accepted this pass
//   data_err_count      mismatching beats (saturating)
//   tlast_err_count     misplaced or missing tlast (saturating)
//   first_err_idx/data  index and data of the first data mismatch
module mm2s_stream_checker #(
    parameter int DATA_W        = 64,
    parameter int WORDS_PER_CMD = 512,
    parameter int NCMD          = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       word_count,
    output logic [31:0]       data_err_count,
    output logic [15:0]       tlast_err_count,
    output logic [31:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int BW = (WORDS_PER_CMD > 1) ? $clog2(WORDS_PER_CMD) : 1;
    localparam int CW = (NCMD > 1) ? $clog2(NCMD) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(WORDS_PER_CMD - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(NCMD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic              r_fl;
    logic              r_tready;
    logic              r_pass;
    logic              r_err_seen;
    logic              r_cap_done;
    logic [BW-1:0]     r_beat;
    logic [CW-1:0]     r_cmd;
    logic [31:0]       r_words;
    logic [31:0]       r_derr;
    logic [15:0]       r_terr;
    logic [31:0]       r_ferr_idx;
    logic [DATA_W-1:0] r_ferr_data;

    // Compare pipeline stage: beat captured at acceptance, compared next cycle
    logic              r_s1_vld;
    logic [31:0]       r_s1_idx;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_terr;

    logic              w_acc;
    logic              w_last;
    logic              w_rdy_nx;
    logic              w_dmis;
    logic [DATA_W-1:0] w_exp;

    assign w_acc  = s_axis_tvalid & r_tready & (r_state == S_RUN);
    assign w_last = (r_cmd == CMD_LAST) & (r_beat == BEAT_LAST);

`ifdef MM2S_CHECKER_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_rdy_nx = (r_lfsr[3:0] != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == S_IDLE && start) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == S_RUN) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end
`else
    assign w_rdy_nx = 1'b1;
`endif

    // Pattern: 32-bit words alternate idx, ~idx ({~i, i} per 64-bit lane)
    always_comb begin
        w_exp = '0;
        for (int k = 0; k < DATA_W / 32; k++) begin
            w_exp[k*32 +: 32] = k[0] ? ~r_s1_idx : r_s1_idx;
        end
    end

    assign w_dmis = (r_s1_data != w_exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_fl        <= 1'b0;
            r_tready    <= 1'b0;
            r_pass      <= 1'b0;
            r_err_seen  <= 1'b0;
            r_cap_done  <= 1'b0;
            r_beat      <= '0;
            r_cmd       <= '0;
            r_words     <= '0;
            r_derr      <= '0;
            r_terr      <= '0;
            r_ferr_idx  <= '0;
            r_ferr_data <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_data   <= '0;
            r_s1_terr   <= 1'b0;
        end else begin
            r_s1_vld <= 1'b0;

            if (r_s1_vld) begin
                if (w_dmis) begin
                    r_err_seen <= 1'b1;
                    if (r_derr != 32'hFFFF_FFFF) begin
                        r_derr <= r_derr + 32'd1;
                    end
                    if (!r_cap_done) begin
                        r_cap_done  <= 1'b1;
                        r_ferr_idx  <= r_s1_idx;
                        r_ferr_data <= r_s1_data;
                    end
                end
                if (r_s1_terr) begin
                    r_err_seen <= 1'b1;
                    if (r_terr != 16'hFFFF) begin
                        r_terr <= r_terr + 16'd1;
                    end
                end
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_tready    <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_seen  <= 1'b0;
                        r_cap_done  <= 1'b0;
                        r_beat      <= '0;
                        r_cmd       <= '0;
                        r_words     <= '0;
                        r_derr      <= '0;
                        r_terr      <= '0;
                        r_ferr_idx  <= '0;
                        r_ferr_data <= '0;
                    end
                end
                S_RUN: begin
                    r_tready <= w_rdy_nx;
                    if (w_acc) begin
                        r_words   <= r_words + 32'd1;
                        r_s1_vld  <= 1'b1;
                        r_s1_idx  <= r_words;
                        r_s1_data <= s_axis_tdata;
                        r_s1_terr <= s_axis_tlast ^ (r_beat == BEAT_LAST);
                        if (r_beat == BEAT_LAST) begin
                            r_beat <= '0;
                            r_cmd  <= r_cmd + CW'(1);
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                        if (w_last) begin
                            r_state  <= S_FLUSH;
                            r_tready <= 1'b0;
                            r_fl     <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    r_fl <= 1'b1;
                    if (r_fl) begin
                        r_state <= S_DONE;
                        r_pass  <= ~r_err_seen;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready   = r_tready;
    assign busy            = (r_state == S_RUN) | (r_state == S_FLUSH);
    assign done            = (r_state == S_DONE);
    assign pass            = r_pass;
    assign word_count      = r_words;
    assign data_err_count  = r_derr;
    assign tlast_err_count = r_terr;
    assign first_err_idx   = r_ferr_idx;
    assign first_err_data  = r_ferr_data;

endmodule

// File: doc/mm2s_stream_checker.md
# mm2s_stream_checker

Consumes the AXI4-Stream data produced by the DataMover MM2S channel during the read-back phase of the DDR soak test. It checks every beat against the deterministic pattern written by the upstream S2MM source and verifies `tlast` placement at every 4096-byte command boundary. It reports word/error counts and first-failure capture to the status register bank. The checker is armed by `start`, concurrently with the command controller's `start`, and runs until the full 2^28-byte region has been read.

## Interface
- `DATA_W`, 64, stream data width; must be a multiple of 32.
- `WORDS_PER_CMD`, 512, beats per DataMover command (4096 B / 8 B).
- `NCMD`, 65536, commands per pass (2^28 / 4096).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  arm checker, clear counters; ignored unless in IDLE.
- `s_axis_tdata`  in  DATA_W  MM2S data.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tlast`  in  1  end of command.
- `s_axis_tready`  out  1  checker accepts beat.
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  one-cycle pulse at end of pass.
- `pass`  out  1  level; high iff last completed pass had zero data and tlast errors.
- `word_count`  out  32  beats accepted this pass.
- `data_err_count`  out  32  mismatching beats, saturating.
- `tlast_err_count`  out  16  misplaced/missing `tlast`, saturating.
- `first_err_idx`  out  32  global beat index of first data mismatch.
- `first_err_data`  out  DATA_W  received data of first mismatch.

## Operation
- States: IDLE -> (start) RUN -> (last beat accepted) FLUSH -> DONE -> IDLE. DONE lasts 1 cycle and drives `done`=1.
- `start` in IDLE clears all counters, `first_err_*`, and an internal `err_seen` flag; `pass` is forced to 0.
- Expected beat for global index i (32-bit): each 64-bit lane = {~i, i}, replicated across DATA_W.
- A beat is accepted when `s_axis_tvalid & s_axis_tready`. Each accepted beat increments `word_count`, the in-command beat counter (wraps at WORDS_PER_CMD), and the command counter on wrap.
- Expected `tlast` = 1 iff the in-command counter == WORDS_PER_CMD-1. A mismatch in either direction increments `tlast_err_count`. Counters are never resynchronised on `tlast`.
- Data mismatch: increment `data_err_count`. On the first mismatch of the pass, capture index and data.
- Both error counters saturate at all-ones; no wrap.
- Last beat = beat with command counter == NCMD-1 and in-command counter == WORDS_PER_CMD-1. Acceptance of the last beat moves the FSM to FLUSH. FLUSH waits for the compare pipeline to drain.
- `pass` is updated at DONE to `~err_seen` and held until the next `start`.
- `start` asserted outside IDLE: no effect.
- `reset` mid-pass: FSM to IDLE, `tready` 0, all counters and `pass` cleared. No partial `done`.

## Timing
- Reset values: `s_axis_tready`=0, `busy`=0, `done`=0, `pass`=0, all counts/captures 0.
- `s_axis_tready` is registered. It goes to 1 the cycle after `start` is sampled in IDLE. It drops the cycle after the last beat is accepted, so no beat beyond the pass is accepted.
- Compare is pipelined by 1 cycle. Error counters and captures update 2 cycles after the beat's acceptance edge. `word_count` updates 1 cycle after.
- FLUSH lasts 2 cycles. `done` pulses 3 cycles after the last beat is accepted. `pass` is valid in that same cycle.
- Sustained throughput: 1 beat/cycle with `tvalid` held high (throttle disabled).

## Configuration
- `MM2S_CHECKER_THROTTLE_EN` defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reseeded on `start`) deasserts `s_axis_tready` for one cycle whenever LFSR[3:0]==0 in RUN. This exercises DataMover backpressure.
- Undefined: `s_axis_tready` is constantly 1 throughout RUN. The LFSR is not built.

## Test plan
- Clean pass, small parameters (WORDS_PER_CMD=4, NCMD=3): 12 correct beats with `tlast` on beats 3, 7, 11 -> `done` pulse, `pass`=1, `word_count`=12, both error counters 0.
- Corrupt beat 5 to 64'h0: `data_err_count`=1, `first_err_idx`=5, `first_err_data`=0, `pass`=0.
- `tlast` on beat 2 instead of 3: `tlast_err_count`=2 (early and missing), data errors 0, `pass`=0.
- Reset asserted after beat 6 -> `tready` 0 the next cycle, counters 0, no `done`. A new `start` then full clean stream gives `pass`=1.
- Every beat wrong, 2^16+3 beats: `data_err_count` saturates at 32'hFFFF_FFFF only if widened. With a 16-bit tlast storm, `tlast_err_count` holds at 16'hFFFF.
- With `MM2S_CHECKER_THROTTLE_EN` and a random-`tvalid` source: clean pass completes, `pass`=1, no beats lost or duplicated (`word_count`=WORDS_PER_CMD*NCMD).
